// File: rtl/temp_adc_reader.sv
// temp_adc_reader
//
// Periodically reads an 8-bit ADC0831-style serial converter. It drives
// chip select and the serial clock, shifts the conversion in MSB first, and
// presents the result as raw (8 bits) and temp (raw[7:3], 5 bits). Both
// outputs hold their value between conversions. temp_valid pulses for one
// cycle on each update.
//
// Parameters
//   CLK_DIV        clock cycles per sclk half-period (>= 2)
//   SAMPLE_PERIOD  idle cycles between conversions (>= 2)
//
// Ports
//   clock       system clock, rising edge
//   clr         asynchronous active-high reset
//   sdo         ADC serial data, sampled on sclk rising ticks
//   hold        blocks new conversions while high (IDLE only)
//   trig        one-cycle request for an immediate conversion (IDLE only)
//   cs_n        ADC chip select, active-low
//   sclk        ADC serial clock, idles low
//   raw         last complete conversion
//   temp        raw[7:3]
//   temp_valid  one-cycle strobe when raw/temp update
//   busy        high from cs_n fall through the temp_valid cycle
//
// State | meaning
// IDLE  | period counter running; waiting for terminal count or trig
// CONV  | cs_n low, generating sclk ticks 1..19 and capturing sdo
// DONE  | one-cycle strobe cycle; raw/temp just updated, cs_n high

module temp_adc_reader #(
    parameter int CLK_DIV       = 50,
    parameter int SAMPLE_PERIOD = 1000000
) (
    input  logic       clock,
    input  logic       clr,
    input  logic       sdo,
    input  logic       hold,
    input  logic       trig,
    output logic       cs_n,
    output logic       sclk,
    output logic [7:0] raw,
    output logic [4:0] temp,
    output logic       temp_valid,
    output logic       busy
);

    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int HW = $clog2(CLK_DIV);

    localparam logic [PW-1:0] PER_TC    = PW'(SAMPLE_PERIOD - 1);
    localparam logic [HW-1:0] HALF_TC   = HW'(CLK_DIV - 1);
    // Tick 19 is the extra half-period after the last sclk fall; it ends
    // the conversion.
    localparam logic [4:0]    LAST_TICK = 5'd19;
    localparam logic [4:0]    FIRST_CAP = 5'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] per_cnt, per_cnt_nx;
    logic [HW-1:0] half_cnt, half_cnt_nx;
    logic [4:0]    tick_cnt, tick_cnt_nx;
    logic [4:0]    tick_inc;
    logic [7:0]    shift, shift_nx;
    logic          cs_n_nx;
    logic          sclk_nx;
    logic [7:0]    raw_nx;
    logic [4:0]    temp_nx;
    logic          temp_valid_nx;
    logic          busy_nx;

    assign tick_inc = tick_cnt + 5'd1;

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            per_cnt    <= '0;
            half_cnt   <= '0;
            tick_cnt   <= '0;
            shift      <= '0;
            cs_n       <= 1'b1;
            sclk       <= 1'b0;
            raw        <= '0;
            temp       <= '0;
            temp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            per_cnt    <= per_cnt_nx;
            half_cnt   <= half_cnt_nx;
            tick_cnt   <= tick_cnt_nx;
            shift      <= shift_nx;
            cs_n       <= cs_n_nx;
            sclk       <= sclk_nx;
            raw        <= raw_nx;
            temp       <= temp_nx;
            temp_valid <= temp_valid_nx;
            busy       <= busy_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        per_cnt_nx    = per_cnt;
        half_cnt_nx   = half_cnt;
        tick_cnt_nx   = tick_cnt;
        shift_nx      = shift;
        cs_n_nx       = cs_n;
        sclk_nx       = sclk;
        raw_nx        = raw;
        temp_nx       = temp;
        temp_valid_nx = 1'b0;
        busy_nx       = busy;

        case (state)
            IDLE: begin
                if (!hold && (trig || per_cnt == PER_TC)) begin
                    state_nx    = CONV;
                    cs_n_nx     = 1'b0;
                    busy_nx     = 1'b1;
                    half_cnt_nx = '0;
                    tick_cnt_nx = '0;
                end else if (per_cnt != PER_TC) begin
                    // Saturates at terminal count while hold keeps us here.
                    per_cnt_nx = per_cnt + PW'(1);
                end
            end

            CONV: begin
                if (half_cnt == HALF_TC) begin
                    half_cnt_nx = '0;
                    tick_cnt_nx = tick_inc;
                    if (tick_inc == LAST_TICK) begin
                        state_nx      = DONE;
                        cs_n_nx       = 1'b1;
                        raw_nx        = shift;
                        temp_nx       = shift[7:3];
                        temp_valid_nx = 1'b1;
                    end else if (tick_inc[0]) begin
                        sclk_nx = 1'b1;
                        // Tick 1 is the dummy start pulse; ticks 3..17
                        // capture MSB first, so after eight shifts bit 7
                        // holds the first captured bit.
                        if (tick_inc >= FIRST_CAP) begin
                            shift_nx = {shift[6:0], sdo};
                        end
                    end else begin
                        sclk_nx = 1'b0;
                    end
                end else begin
                    half_cnt_nx = half_cnt + HW'(1);
                end
            end

            DONE: begin
                state_nx   = IDLE;
                busy_nx    = 1'b0;
                per_cnt_nx = '0;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
